// File: rtl/fpu_issue_ctrl_if.sv
// Decode, FPU and writeback signals of the FP issue controller.
// The controller takes the slave view; the surrounding pipeline takes the master view.
interface fpu_issue_ctrl_if;
    // decode side
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] in_c;
    logic [4:0]  in_rd;
    logic        in_rd_fp;
    logic        flush;

    // FPU side
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [31:0] fpu_c;
    logic [4:0]  fpu_sel;
    logic        fpu_stall;
    logic [31:0] fpu_res;

    // writeback side
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_rd_fp;
    logic        wb_timeout;
    logic [31:0] fp_pend;

    modport master (
        output in_valid, in_op, in_a, in_b, in_c, in_rd, in_rd_fp, flush,
               fpu_stall, fpu_res, wb_ready,
        input  in_ready, fpu_a, fpu_b, fpu_c, fpu_sel,
               wb_valid, wb_data, wb_rd, wb_rd_fp, wb_timeout, fp_pend
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_c, in_rd, in_rd_fp, flush,
               fpu_stall, fpu_res, wb_ready,
        output in_ready, fpu_a, fpu_b, fpu_c, fpu_sel,
               wb_valid, wb_data, wb_rd, wb_rd_fp, wb_timeout, fp_pend
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Single-op issue/completion controller in front of the FPU execute block.
// Holds the op stable across FPU stalls, bounds stalls with a timeout and tracks pending FP dests.
module fpu_issue_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CNT_W       = 7,
    parameter logic [4:0]  IDLE_SEL    = 5'b11111,
    parameter logic [31:0] NAN_VAL     = 32'h7fc0_0000
) (
    input logic             g_clk,
    input logic             g_rst,
    fpu_issue_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      a_q, b_q, c_q;
    logic [31:0]      res_q;
    logic [31:0]      pend_q, pend_d, set_mask, clr_mask;
    logic [4:0]       sel_q, rd_q;
    logic             rd_fp_q;
    logic             timeout_q;
    logic             resp_pend_q;   // DRAIN is holding a timeout response for writeback

    logic accept, capture, time_out, pend_clr, drop;
    logic wait_limit;

    assign wait_limit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge g_clk or negedge g_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
        if (!g_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d  = state_q;
        accept   = 1'b0;
        capture  = 1'b0;
        time_out = 1'b0;
        pend_clr = 1'b0;
        drop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && !bus.flush) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE, WAIT: begin
                if (bus.flush) begin
                    pend_clr = 1'b1;
                    state_d  = bus.fpu_stall ? DRAIN : IDLE;
                end else if (!bus.fpu_stall) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else if (state_q == ISSUE) begin
                    state_d = WAIT;
                end else if (wait_limit) begin
                    time_out = 1'b1;
                    state_d  = DRAIN;
                end
            end
            RESP: begin
                // flush and handshake both retire the op; only the handshake delivers it
                if (bus.flush || bus.wb_ready) begin
                    pend_clr = 1'b1;
                    state_d  = IDLE;
                end
            end
            DRAIN: begin
                if (bus.flush && resp_pend_q) begin
                    drop     = 1'b1;
                    pend_clr = 1'b1;
                end
                if (!bus.fpu_stall) begin
                    state_d = (resp_pend_q && !bus.flush) ? RESP : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear wins over set; with one op in flight they never target the same bit anyway.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (accept && bus.in_rd_fp) set_mask[bus.in_rd] = 1'b1;
        if (pend_clr && rd_fp_q)    clr_mask[rd_q]      = 1'b1;
        pend_d = (pend_q | set_mask) & ~clr_mask;
    end

    always_ff @(posedge g_clk or negedge g_rst) begin
        if (!g_rst) begin
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            sel_q       <= IDLE_SEL;
            rd_q        <= '0;
            rd_fp_q     <= 1'b0;
            res_q       <= '0;
            pend_q      <= '0;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            resp_pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;

            if (accept) begin
                a_q     <= bus.in_a;
                b_q     <= bus.in_b;
                c_q     <= bus.in_c;
                sel_q   <= bus.in_op;
                rd_q    <= bus.in_rd;
                rd_fp_q <= bus.in_rd_fp;
            end else if (state_d == IDLE || state_d == RESP) begin
                sel_q <= IDLE_SEL;
            end

            if (state_q == ISSUE)     cnt_q <= '0;
            else if (state_q == WAIT) cnt_q <= cnt_q + CNT_W'(1);

            if (capture)       res_q <= bus.fpu_res;
            else if (time_out) res_q <= NAN_VAL;

            if (time_out)              timeout_q <= 1'b1;
            else if (state_d == IDLE)  timeout_q <= 1'b0;

            if (time_out) begin
                resp_pend_q <= 1'b1;
            end else if (drop || (state_q == DRAIN && !bus.fpu_stall)) begin
                resp_pend_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = (state_q == IDLE) && !bus.flush;
    assign bus.fpu_a      = a_q;
    assign bus.fpu_b      = b_q;
    assign bus.fpu_c      = c_q;
    assign bus.fpu_sel    = sel_q;
    assign bus.wb_valid   = (state_q == RESP);
    assign bus.wb_data    = res_q;
    assign bus.wb_rd      = rd_q;
    assign bus.wb_rd_fp   = rd_fp_q;
    assign bus.wb_timeout = timeout_q;
    assign bus.fp_pend    = pend_q;

endmodule
